// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
package mult_pkg;

    localparam int unsigned MULT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned W x W multiplier: drives one external W-bit adder through W
// shift-and-add steps and registers the 2W-bit product.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned W  = MULT_W,
    parameter int unsigned CW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic [W-1:0]   add_op_a,
    output logic [W-1:0]   add_op_b,
    input  logic [W-1:0]   add_sum,
    input  logic           add_cout,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam logic [CW-1:0] LastStep = CW'(W - 1);

    mult_state_e    state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   acc_hi_q, acc_hi_d;
    logic [W-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] product_q, product_d;
    logic [2*W-1:0] acc_shift;

    // Adder operands come straight from registers so they are never X outside RUN.
    assign add_op_a = acc_hi_q;
    assign add_op_b = acc_lo_q[0] ? mcand_q : '0;

    // Carry lands in the new MSB; the consumed multiplier bit falls off the bottom.
    assign acc_shift = {add_cout, add_sum, acc_lo_q[W-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    acc_hi_d = '0;
                    acc_lo_d = multiplier;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_hi_d = acc_shift[2*W-1:W];
                acc_lo_d = acc_shift[W-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LastStep) begin
                    product_d = acc_shift;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl with a behavioural adder beside it.
module tb_shift_add_mult_ctrl;
    import mult_pkg::*;

    localparam int unsigned W = MULT_W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   add_op_a, add_op_b, add_sum;
    logic           add_cout;
    logic           busy, done;
    logic [2*W-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] prev_prod = '0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_op_a} + {1'b0, add_op_b};

    shift_add_mult_ctrl #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_op_a     (add_op_a),
        .add_op_b     (add_op_b),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; checks latency, busy width, product hold and result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [2*W-1:0] exp_prod;
        int cyc;
        int busy_cyc;
        int hold_bad;
        exp_prod     = (2*W)'(a) * (2*W)'(b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        tick();
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        cyc      = 0;
        busy_cyc = 0;
        hold_bad = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            if (product !== prev_prod) hold_bad++;
            tick();
            cyc++;
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'(W));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W));
        check_eq({tag, "_hold"}, 64'(hold_bad), 64'd0);
        check_eq({tag, "_product"}, 64'(product), 64'(exp_prod));
        check_eq({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        tick();
        check_eq({tag, "_done_width"}, 64'(done), 64'd0);
        prev_prod = exp_prod;
    endtask

    initial begin
        int n_done;
        int done_cyc[$];
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_product", 64'(product), 64'd0);
        check_eq("rst_op_a", 64'(add_op_a), 64'd0);
        check_eq("rst_op_b", 64'(add_op_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(16'h0003, 16'h0005, "3x5");
        run_op(16'hFFFF, 16'hFFFF, "max");
        run_op(16'h1234, 16'h0000, "zero");
        run_op(16'h0001, 16'hBEEF, "ident");

        // start re-pulsed during RUN and in the DONE cycle must be ignored
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= W + 8; i++) begin
            start = 1'b0;
            if (i == 5) begin
                start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
            end
            if (done) begin
                n_done++;
                start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
            end
            tick();
        end
        start = 1'b0;
        check_eq("ign_done_count", 64'(n_done), 64'd1);
        check_eq("ign_product", 64'(product), 64'd63);
        check_eq("ign_idle", 64'(busy), 64'd0);
        prev_prod = 64'd63;

        // Reset in the middle of a run discards everything
        start = 1'b1; multiplicand = 16'h00FF; multiplier = 16'h0100;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_product", 64'(product), 64'd0);
        n_done = 0;
        repeat (3) begin
            tick();
            if (done) n_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            if (done) n_done++;
        end
        check_eq("midrst_no_done", 64'(n_done), 64'd0);
        prev_prod = '0;
        run_op(16'd2, 16'd3, "after_rst");

        // Back-to-back with start held high
        start = 1'b1; multiplicand = 16'h0010; multiplier = 16'h0010;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done) begin
                done_cyc.push_back(c);
                check_eq("b2b_product", 64'(product), 64'h100);
            end
        end
        start = 1'b0;
        check_eq("b2b_count", 64'(done_cyc.size()), 64'd4);
        for (int k = 1; k < done_cyc.size(); k++)
            check_eq("b2b_interval", 64'(done_cyc[k] - done_cyc[k-1]), 64'd18);
        repeat (W + 4) tick();
        check_eq("b2b_idle", 64'(busy), 64'd0);
        prev_prod = 64'h100;

        // Random operands, with corner values mixed in
        for (int n = 0; n < 25; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 5) == 0) ra = '1;
            if ($urandom_range(0, 5) == 0) rb = ($urandom_range(0, 1) == 0) ? '0 : '1;
            run_op(ra, rb, "rand");
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
